// File: rtl/pdm_ctrl_pkg.sv
// Shared types and constants for the PDM microphone front-end sequencer.
// Optional build macro used by the top: PDM_DECIM_CTRL_STATS_EN.
package pdm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } pdm_state_t;

    localparam logic signed [7:0] PDM_ONE  = 8'hFF;
    localparam logic signed [7:0] PDM_ZERO = 8'h00;

    function automatic logic signed [7:0] pdm_to_sample(input logic bit_in);
        return bit_in ? PDM_ONE : PDM_ZERO;
    endfunction

endpackage

// File: rtl/mic_clk_gen.sv
// Microphone clock generator: phase counter, registered mic clock, and a
// pulse that is high in the cycle just before the mic clock rises.
module mic_clk_gen #(
    parameter int unsigned PERIOD = 32
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en_in,
    input  logic clr_in,
    output logic mic_clk_out,
    output logic rise_next_out
);

    localparam int unsigned PH_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [PH_W-1:0] ph_q, ph_d;
    logic            mic_clk_q, mic_clk_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        ph_d      = ph_q;
        mic_clk_d = 1'b0;
        if (clr_in) begin
            ph_d = '0;
        end else if (en_in) begin
            mic_clk_d = (ph_q < PH_W'(PERIOD / 2));
            ph_d      = (ph_q == PH_W'(PERIOD - 1)) ? '0 : ph_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ph_q      <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk_out   = mic_clk_q;
    assign rise_next_out = en_in && !clr_in && (ph_q == '0);

endmodule

// File: rtl/pdm_decim_ctrl.sv
// PDM front-end sequencer: mic clock, bit capture to the FIR, and decimated
// sample handoff. Define PDM_DECIM_CTRL_STATS_EN to add drop_count_out.
module pdm_decim_ctrl
    import pdm_ctrl_pkg::*;
#(
    parameter int unsigned PDM_COUNT_PERIOD = 32,
    parameter int unsigned DECIM            = 16,
    parameter int unsigned WARMUP_EDGES     = 1024
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               mic_data_in,
    output logic               mic_clk_out,
    output logic signed [7:0]  fir_audio_out,
    output logic               fir_valid_out,
    input  logic               fir_ready_in,
    input  logic signed [15:0] fir_data_in,
    input  logic               fir_data_valid_in,
    output logic signed [15:0] sample_out,
    output logic               sample_valid_out,
    input  logic               sample_ready_in,
    output logic               overrun_out
`ifdef PDM_DECIM_CTRL_STATS_EN
    ,
    output logic [15:0]        drop_count_out
`endif
);

    localparam int unsigned EC_W = (WARMUP_EDGES > 0) ? $clog2(WARMUP_EDGES + 1) : 1;
    localparam int unsigned DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    // NOTE: reset asserts asynchronously but is released only after two clean clk_in edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    pdm_state_t         state_q, state_d;
    logic [EC_W-1:0]    ec_q, ec_d;
    logic [DC_W-1:0]    dc_q, dc_d;
    logic signed [7:0]  audio_q, audio_d;
    logic               fir_valid_q, fir_valid_d;
    logic signed [15:0] sample_q, sample_d;
    logic               sample_valid_q, sample_valid_d;
    logic               overrun_q, overrun_d;
    logic               drop_bit, drop_sample;
    logic               rise_next;

    mic_clk_gen #(
        .PERIOD(PDM_COUNT_PERIOD)
    ) u_mic_clk_gen (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .en_in        (state_q != IDLE),
        .clr_in       (!enable_in),
        .mic_clk_out  (mic_clk_out),
        .rise_next_out(rise_next)
    );

    always_comb begin
        state_d        = state_q;
        ec_d           = ec_q;
        dc_d           = dc_q;
        audio_d        = audio_q;
        fir_valid_d    = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = overrun_q;
        drop_bit       = 1'b0;
        drop_sample    = 1'b0;

        if (sample_valid_q && sample_ready_in) sample_valid_d = 1'b0;

        if (rise_next) audio_d = pdm_to_sample(mic_data_in);

        if (!enable_in) begin
            state_d        = IDLE;
            ec_d           = '0;
            dc_d           = '0;
            sample_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WARMUP;
                WARMUP: begin
                    if (ec_q == EC_W'(WARMUP_EDGES)) state_d = RUN;
                    else if (rise_next)              ec_d    = ec_q + 1'b1;
                end
                RUN: begin
                    if (rise_next) begin
                        if (fir_ready_in) fir_valid_d = 1'b1;
                        else              drop_bit    = 1'b1;
                    end
                    if (fir_data_valid_in) begin
                        if (dc_q == DC_W'(DECIM - 1)) begin
                            dc_d = '0;
                            // A slot frees up if the held sample is consumed this same cycle.
                            if (!sample_valid_q || sample_ready_in) begin
                                sample_d       = fir_data_in;
                                sample_valid_d = 1'b1;
                            end else begin
                                drop_sample = 1'b1;
                            end
                        end else begin
                            dc_d = dc_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (drop_bit || drop_sample) overrun_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ec_q           <= '0;
            dc_q           <= '0;
            audio_q        <= PDM_ZERO;
            fir_valid_q    <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ec_q           <= ec_d;
            dc_q           <= dc_d;
            audio_q        <= audio_d;
            fir_valid_q    <= fir_valid_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign fir_audio_out    = audio_q;
    assign fir_valid_out    = fir_valid_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = sample_valid_q;
    assign overrun_out      = overrun_q;

`ifdef PDM_DECIM_CTRL_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // A bit and a sample can both be lost in one cycle, so the step can be 2.
    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_bit) + 17'(drop_sample);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_decim_ctrl.sv
// Self-checking bench for pdm_decim_ctrl with P=4, DECIM=4, WARMUP_EDGES=2,
// comparing every cycle against a behavioural model derived from mic-clock arithmetic.
module tb_pdm_decim_ctrl;

    localparam int P = 4;
    localparam int D = 4;
    localparam int W = 2;

    logic               clk_in;
    logic               rst_in;
    logic               enable_in;
    logic               mic_data_in;
    logic               mic_clk_out;
    logic signed [7:0]  fir_audio_out;
    logic               fir_valid_out;
    logic               fir_ready_in;
    logic signed [15:0] fir_data_in;
    logic               fir_data_valid_in;
    logic signed [15:0] sample_out;
    logic               sample_valid_out;
    logic               sample_ready_in;
    logic               overrun_out;
`ifdef PDM_DECIM_CTRL_STATS_EN
    logic [15:0]        drop_count_out;
`endif

    pdm_decim_ctrl #(
        .PDM_COUNT_PERIOD(P),
        .DECIM           (D),
        .WARMUP_EDGES    (W)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .mic_data_in      (mic_data_in),
        .mic_clk_out      (mic_clk_out),
        .fir_audio_out    (fir_audio_out),
        .fir_valid_out    (fir_valid_out),
        .fir_ready_in     (fir_ready_in),
        .fir_data_in      (fir_data_in),
        .fir_data_valid_in(fir_data_valid_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .overrun_out      (overrun_out)
`ifdef PDM_DECIM_CTRL_STATS_EN
        ,
        .drop_count_out   (drop_count_out)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int total = 0;
    int bad   = 0;

    // Model: n = clock edges since the enable was first seen; rises land at n = 1 + k*P.
    bit          m_on;
    int          n;
    int          m_hold;
    int          m_words;
    logic        m_mic, m_fv, m_sv, m_ovr;
    logic [7:0]  m_audio;
    logic [15:0] m_sample;
    logic [15:0] m_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t n=%0d)", tag, obs, exp, $time, n);
        end
    endtask

    task automatic model_clear();
        m_on = 1'b0; n = 0; m_words = 0;
        m_mic = 1'b0; m_fv = 1'b0; m_sv = 1'b0; m_ovr = 1'b0;
        m_audio = 8'h00; m_sample = 16'h0000; m_drops = 16'h0000;
    endtask

    task automatic model_drop();
        m_ovr = 1'b1;
        if (m_drops != 16'hFFFF) m_drops++;
    endtask

    task automatic compare_all();
        check("mic_clk", mic_clk_out, m_mic);
        check("fir_valid", fir_valid_out, m_fv);
        check("fir_audio", $unsigned(fir_audio_out), m_audio);
        check("sample_valid", sample_valid_out, m_sv);
        check("sample_out", $unsigned(sample_out), m_sample);
        check("overrun", overrun_out, m_ovr);
`ifdef PDM_DECIM_CTRL_STATS_EN
        check("drop_count", drop_count_out, m_drops);
`endif
    endtask

    // One clock: update the model from the inputs present at the edge, then compare.
    task automatic step();
        bit free;
        @(posedge clk_in);
        if (!rst_in) begin
            model_clear();
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (!enable_in) begin
            m_on = 1'b0; m_mic = 1'b0; m_fv = 1'b0; m_sv = 1'b0;
        end else begin
            if (!m_on) begin
                m_on = 1'b1; n = 0; m_words = 0;
            end else begin
                n++;
            end
            m_mic = (n >= 1) && (((n - 1) % P) < P / 2);
            m_fv  = 1'b0;
            if (n >= 1 && ((n - 1) % P) == 0) begin
                m_audio = mic_data_in ? 8'hFF : 8'h00;
                if ((n - 1) / P + 1 > W) begin
                    if (fir_ready_in) m_fv = 1'b1;
                    else              model_drop();
                end
            end
            free = !m_sv || sample_ready_in;
            if (m_sv && sample_ready_in) m_sv = 1'b0;
            if (fir_data_valid_in && n >= W * P + 1) begin
                m_words++;
                if (m_words % D == 0) begin
                    if (free) begin
                        m_sv = 1'b1;
                        m_sample = fir_data_in;
                    end else begin
                        model_drop();
                    end
                end
            end
        end
        #1;
        compare_all();
    endtask

    // Steps with the mic bit changed once per period, mid-way between rises.
    task automatic run_steps(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            if (m_on && (n % P) == P / 2) mic_data_in = 1'($urandom);
            step();
        end
    endtask

    task automatic fir_pulse(input logic [15:0] val);
        fir_data_valid_in = 1'b1;
        fir_data_in = val;
        step();
        fir_data_valid_in = 1'b0;
        step();
    endtask

    initial begin
        rst_in = 1'b0; enable_in = 1'b0; mic_data_in = 1'b0; fir_ready_in = 1'b1;
        fir_data_in = '0; fir_data_valid_in = 1'b0; sample_ready_in = 1'b0;
        m_hold = 0;
        model_clear();

        // Reset state, then release with the enable low.
        #3;
        compare_all();
        repeat (2) step();
        rst_in = 1'b1;
        m_hold = 2;
        repeat (3) step();

        // Warmup: two discarded rises, the third carries 8'hFF, then every P cycles.
        enable_in = 1'b1; mic_data_in = 1'b1; sample_ready_in = 1'b1;
        fir_data_valid_in = 1'b1; fir_data_in = 16'h7777;
        repeat (3) step();
        fir_data_valid_in = 1'b0;
        repeat (W * P - 1) step();
        check("first_strobe", fir_valid_out, 1'b1);
        check("first_audio", $unsigned(fir_audio_out), 8'hFF);
        run_steps(3 * P);

        // Decimation with the downstream always ready: samples 4 and 8.
        for (int i = 1; i <= 8; i++) fir_pulse(16'(i));
        check("decim_last", $unsigned(sample_out), 16'd8);
        check("decim_no_overrun", overrun_out, 1'b0);

        // Held sample: downstream stalled, the second sample is lost.
        sample_ready_in = 1'b0;
        for (int i = 1; i <= 8; i++) fir_pulse(16'(i));
        check("held_value", $unsigned(sample_out), 16'd4);
        check("held_overrun", overrun_out, 1'b1);
        sample_ready_in = 1'b1;
        repeat (2) step();

        // Consume and reload in the same cycle keeps valid high with the new value.
        sample_ready_in = 1'b0;
        for (int i = 11; i <= 17; i++) fir_pulse(16'(i));
        sample_ready_in = 1'b1;
        fir_data_valid_in = 1'b1; fir_data_in = 16'd18;
        step();
        fir_data_valid_in = 1'b0;
        check("reload_valid", sample_valid_out, 1'b1);
        check("reload_value", $unsigned(sample_out), 16'd18);
        run_steps(2);

        // Mid-run disable with the phase at 2, then re-enable repeats the warmup.
        for (int k = 0; k < P && (n % P) != 2; k++) run_steps(1);
        enable_in = 1'b0;
        step();
        check("disable_mic_low", mic_clk_out, 1'b0);
        run_steps(7);
        enable_in = 1'b1; mic_data_in = 1'b0;
        run_steps(W * P + 2 + 2 * P);

        // Asynchronous reset in the middle of RUN.
        mic_data_in = 1'b1;
        run_steps(P);
        sample_ready_in = 1'b0;
        fir_pulse(16'hBEEF); fir_pulse(16'h1234); fir_pulse(16'h0042); fir_pulse(16'hA5A5);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_mic", mic_clk_out, 1'b0);
        check("async_fir_valid", fir_valid_out, 1'b0);
        check("async_audio", $unsigned(fir_audio_out), 8'h00);
        check("async_sample_valid", sample_valid_out, 1'b0);
        check("async_sample", $unsigned(sample_out), 16'h0000);
        check("async_overrun", overrun_out, 1'b0);
        model_clear();
        repeat (2) step();
        rst_in = 1'b1;
        m_hold = 2;
        sample_ready_in = 1'b1;
        run_steps(2 + W * P + 2 + P);

        // FIR backpressure across one rise: no strobe, sticky overrun.
        for (int k = 0; k < P && (n % P) != 2; k++) run_steps(1);
        fir_ready_in = 1'b0;
        run_steps(P);
        fir_ready_in = 1'b1;
        check("bp_overrun", overrun_out, 1'b1);
        run_steps(2 * P);

        // Randomised traffic with occasional disables.
        for (int k = 0; k < 400; k++) begin
            enable_in         = ($urandom_range(0, 79) != 0);
            fir_ready_in      = ($urandom_range(0, 6) != 0);
            sample_ready_in   = 1'($urandom);
            fir_data_in       = 16'($urandom);
            fir_data_valid_in = (m_on && n >= W * P) ? 1'($urandom) : 1'b0;
            run_steps(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
